// File: rtl/color_pkg.sv
// rtl/color_pkg.sv - colour codes, filter-select codes and FSM encodings shared by the colour sensor path
package color_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    RED   = 2'd1,
    GREEN = 2'd2,
    BLUE  = 2'd3
  } color_e;

  // TCS3200 {S2,S3} filter codes
  localparam logic [1:0] FILT_RED   = 2'b00;
  localparam logic [1:0] FILT_BLUE  = 2'b01;
  localparam logic [1:0] FILT_CLEAR = 2'b10;
  localparam logic [1:0] FILT_GREEN = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    GATE     = 2'd2,
    CLASSIFY = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CH_RED   = 2'd0,
    CH_GREEN = 2'd1,
    CH_BLUE  = 2'd2,
    CH_CLEAR = 2'd3
  } chan_e;

  function automatic logic [1:0] chan_filter(input chan_e ch);
    case (ch)
      CH_RED:   return FILT_RED;
      CH_GREEN: return FILT_GREEN;
      CH_BLUE:  return FILT_BLUE;
      default:  return FILT_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/sig_edge_sync.sv
// rtl/sig_edge_sync.sv - 2-FF synchroniser followed by a registered rising-edge pulse
module sig_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic meta_q, sync_q, prev_q, pulse_q;
  logic pulse_d;

  always_comb begin
    pulse_d = sync_q & ~prev_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= din;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/color_freq_sensor.sv
// rtl/color_freq_sensor.sv - sweeps TCS3200 filters, counts output edges per gate window, classifies colour
module color_freq_sensor
  import color_pkg::*;
#(
  parameter int GATE_CYCLES   = 100000,
  parameter int SETTLE_CYCLES = 10000,
  parameter int CNT_W         = 16,
  parameter int MIN_CLEAR     = 50
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             colorsignal,
  output logic             S0,
  output logic             S1,
  output logic             S2,
  output logic             S3,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] blue_cnt,
  output logic [CNT_W-1:0] clear_cnt,
  output logic [1:0]       color,
  output logic             color_valid
);

  localparam logic [31:0]      SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0]      GATE_LAST   = 32'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CLEAR_MIN   = CNT_W'(MIN_CLEAR);

  state_e           state_q, state_d;
  chan_e            chan_q, chan_d;
  logic [31:0]      timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_next;
  logic [CNT_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d, clear_q, clear_d;
  color_e           color_q, color_d, class_color;
  logic             valid_q, valid_d;
  logic             edge_pulse;

  sig_edge_sync u_sync (
    .clock (clock),
    .reset (reset),
    .din   (colorsignal),
    .pulse (edge_pulse)
  );

  // Saturating edge count including the edge seen this cycle
  always_comb begin
    cnt_next = cnt_q;
    if (edge_pulse && (cnt_q != CNT_MAX)) cnt_next = cnt_q + CNT_ONE;
  end

  // Ties resolve red > green > blue by comparison order
  always_comb begin
    class_color = BLUE;
    if (clear_q < CLEAR_MIN)                          class_color = NONE;
    else if ((red_q >= green_q) && (red_q >= blue_q)) class_color = RED;
    else if (green_q >= blue_q)                       class_color = GREEN;
  end

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    clear_d = clear_q;
    color_d = color_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        cnt_d   = '0;
        chan_d  = CH_RED;
        if (enable) state_d = SETTLE;
      end
      SETTLE: begin
        cnt_d = '0;
        if (!enable) begin
          state_d = IDLE;
          chan_d  = CH_RED;
          timer_d = '0;
        end else if (timer_q == SETTLE_LAST) begin
          state_d = GATE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      GATE: begin
        if (!enable) begin
          state_d = IDLE;
          chan_d  = CH_RED;
          timer_d = '0;
          cnt_d   = '0;
        end else if (timer_q == GATE_LAST) begin
          timer_d = '0;
          cnt_d   = '0;
          state_d = SETTLE;
          case (chan_q)
            CH_RED:   begin red_d   = cnt_next; chan_d = CH_GREEN; end
            CH_GREEN: begin green_d = cnt_next; chan_d = CH_BLUE;  end
            CH_BLUE:  begin blue_d  = cnt_next; chan_d = CH_CLEAR; end
            default:  begin clear_d = cnt_next; state_d = CLASSIFY; end
          endcase
        end else begin
          timer_d = timer_q + 32'd1;
          cnt_d   = cnt_next;
        end
      end
      CLASSIFY: begin
        color_d = class_color;
        valid_d = 1'b1;
        chan_d  = CH_RED;
        timer_d = '0;
        cnt_d   = '0;
        state_d = enable ? SETTLE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      chan_q  <= CH_RED;
      timer_q <= '0;
      cnt_q   <= '0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      clear_q <= '0;
      color_q <= NONE;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      clear_q <= clear_d;
      color_q <= color_d;
      valid_q <= valid_d;
    end
  end

  assign S0          = 1'b1;
  assign S1          = 1'b0;
  assign {S2, S3}    = chan_filter(chan_q);
  assign red_cnt     = red_q;
  assign green_cnt   = green_q;
  assign blue_cnt    = blue_q;
  assign clear_cnt   = clear_q;
  assign color       = color_q;
  assign color_valid = valid_q;

endmodule

// File: tb/tb_color_freq_sensor.sv
// tb/tb_color_freq_sensor.sv - directed self-checking bench for color_freq_sensor
module tb_color_freq_sensor;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic colorsignal = 1'b0;
  logic s0, s1, s2, s3;
  logic [15:0] red_cnt, green_cnt, blue_cnt, clear_cnt;
  logic [1:0] color;
  logic color_valid;

  logic reset2 = 1'b1;
  logic enable2 = 1'b0;
  logic colorsignal2 = 1'b0;
  logic t0, t1, t2, t3;
  logic [3:0] r2, g2, b2, c2;
  logic [1:0] color2;
  logic valid2;

  int per_red = 4, per_green = 10, per_blue = 20, per_clear = 2;
  int tests = 0, fails = 0;

  always #5 clock = ~clock;

  color_freq_sensor #(.GATE_CYCLES(100), .SETTLE_CYCLES(10), .CNT_W(16), .MIN_CLEAR(20)) dut (
    .clock(clock), .reset(reset), .enable(enable), .colorsignal(colorsignal),
    .S0(s0), .S1(s1), .S2(s2), .S3(s3),
    .red_cnt(red_cnt), .green_cnt(green_cnt), .blue_cnt(blue_cnt), .clear_cnt(clear_cnt),
    .color(color), .color_valid(color_valid)
  );

  color_freq_sensor #(.GATE_CYCLES(100), .SETTLE_CYCLES(10), .CNT_W(4), .MIN_CLEAR(10)) dut_sat (
    .clock(clock), .reset(reset2), .enable(enable2), .colorsignal(colorsignal2),
    .S0(t0), .S1(t1), .S2(t2), .S3(t3),
    .red_cnt(r2), .green_cnt(g2), .blue_cnt(b2), .clear_cnt(c2),
    .color(color2), .color_valid(valid2)
  );

  function automatic int period_for(input logic [1:0] filt);
    case (filt)
      2'b00:   return per_red;
      2'b11:   return per_green;
      2'b01:   return per_blue;
      default: return per_clear;
    endcase
  endfunction

  // Sensor model: square wave whose period follows the selected filter
  initial begin
    int ph = 0;
    int p;
    forever begin
      @(negedge clock);
      p = period_for({s2, s3});
      ph = ph + 1;
      if (ph >= p) ph = 0;
      colorsignal = (ph < p / 2);
    end
  end

  initial begin
    int ph = 0;
    int p;
    forever begin
      @(negedge clock);
      p = period_for({t2, t3});
      ph = ph + 1;
      if (ph >= p) ph = 0;
      colorsignal2 = (ph < p / 2);
    end
  end

  task automatic wait_valid(input int limit, output int cyc);
    cyc = -1;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clock);
      #1;
      if (color_valid) begin
        cyc = k;
        return;
      end
    end
  endtask

  task automatic test_reset;
    #3 reset = 1'b1;
    #1;
    tests++;
    if ({s0, s1, s2, s3} !== 4'b1000) begin
      fails++; $display("FAIL reset_pins: got %b expected 1000", {s0, s1, s2, s3});
    end
    tests++;
    if ({red_cnt, green_cnt, blue_cnt, clear_cnt} !== 64'd0 || color !== 2'd0 || color_valid !== 1'b0) begin
      fails++; $display("FAIL reset_regs: got r%0d g%0d b%0d c%0d col%0d v%0d expected all 0",
                        red_cnt, green_cnt, blue_cnt, clear_cnt, color, color_valid);
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_nominal;
    logic [1:0] seq[$];
    logic [1:0] last;
    int cyc;
    per_red = 4; per_green = 10; per_blue = 20; per_clear = 2;
    @(negedge clock);
    enable = 1'b1;
    @(posedge clock);
    cyc = -1;
    last = {s2, s3};
    seq.push_back(last);
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clock);
      #1;
      if ({s2, s3} != last && !color_valid) begin
        last = {s2, s3};
        seq.push_back(last);
      end
      if (color_valid) begin
        cyc = k;
        break;
      end
    end
    tests++;
    if (cyc != 441) begin
      fails++; $display("FAIL nominal_latency: got %0d expected 441", cyc);
    end
    tests++;
    if (seq.size() != 4 || seq[0] !== 2'b00 || seq[1] !== 2'b11 || seq[2] !== 2'b01 || seq[3] !== 2'b10) begin
      fails++; $display("FAIL nominal_filter_seq: got %0d entries expected 00,11,01,10", seq.size());
    end
    tests++;
    if (red_cnt < 24 || red_cnt > 26) begin
      fails++; $display("FAIL nominal_red: got %0d expected 25+-1", red_cnt);
    end
    tests++;
    if (green_cnt < 9 || green_cnt > 11) begin
      fails++; $display("FAIL nominal_green: got %0d expected 10+-1", green_cnt);
    end
    tests++;
    if (blue_cnt < 4 || blue_cnt > 6) begin
      fails++; $display("FAIL nominal_blue: got %0d expected 5+-1", blue_cnt);
    end
    tests++;
    if (clear_cnt < 49 || clear_cnt > 51) begin
      fails++; $display("FAIL nominal_clear: got %0d expected 50+-1", clear_cnt);
    end
    tests++;
    if (color !== 2'd1) begin
      fails++; $display("FAIL nominal_color: got %0d expected 1", color);
    end
    // Frame rolls straight into the next one; set up the tie stimulus now
    per_red = 10; per_green = 10; per_blue = 10; per_clear = 2;
    @(posedge clock);
    #1;
    tests++;
    if (color_valid !== 1'b0) begin
      fails++; $display("FAIL nominal_pulse_width: got %b expected 0", color_valid);
    end
  endtask

  task automatic test_tie_blue;
    int cyc;
    wait_valid(1000, cyc);
    tests++;
    if (cyc < 0 || color !== 2'd1) begin
      fails++; $display("FAIL tie_red: got color %0d (wait %0d) expected 1", color, cyc);
    end
    per_blue = 4;
    wait_valid(1000, cyc);
    tests++;
    if (cyc < 0 || color !== 2'd3) begin
      fails++; $display("FAIL blue_wins: got color %0d (wait %0d) expected 3", color, cyc);
    end
    tests++;
    if (blue_cnt < 24 || blue_cnt > 26) begin
      fails++; $display("FAIL blue_cnt: got %0d expected 25+-1", blue_cnt);
    end
  endtask

  task automatic test_dark;
    int cyc;
    per_red = 5; per_green = 10; per_blue = 10; per_clear = 20;
    wait_valid(1000, cyc);
    tests++;
    if (cyc < 0 || color !== 2'd0) begin
      fails++; $display("FAIL dark_none: got color %0d (wait %0d) expected 0", color, cyc);
    end
    tests++;
    if (clear_cnt < 4 || clear_cnt > 6) begin
      fails++; $display("FAIL dark_clear: got %0d expected 5+-1", clear_cnt);
    end
  endtask

  task automatic test_abort;
    int cyc;
    int pulses;
    int found;
    per_red = 4; per_green = 4; per_blue = 10; per_clear = 2;
    found = 0;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clock);
      #1;
      if ({s2, s3} == 2'b11) begin
        found = 1;
        break;
      end
    end
    tests++;
    if (found != 1) begin
      fails++; $display("FAIL abort_reach_green: got %0d expected 1", found);
    end
    repeat (40) @(posedge clock);
    @(negedge clock);
    enable = 1'b0;
    @(posedge clock);
    #1;
    tests++;
    if ({s2, s3} !== 2'b00) begin
      fails++; $display("FAIL abort_filter: got %b expected 00", {s2, s3});
    end
    pulses = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clock);
      #1;
      if (color_valid) pulses++;
    end
    tests++;
    if (pulses != 0) begin
      fails++; $display("FAIL abort_no_pulse: got %0d expected 0", pulses);
    end
    tests++;
    if (red_cnt < 24 || red_cnt > 26 || green_cnt < 9 || green_cnt > 11 || color !== 2'd0) begin
      fails++; $display("FAIL abort_hold: got r%0d g%0d col%0d expected r25+-1 g10+-1 col0",
                        red_cnt, green_cnt, color);
    end
    @(negedge clock);
    enable = 1'b1;
    @(posedge clock);
    wait_valid(1000, cyc);
    tests++;
    if (cyc != 441 || color !== 2'd1) begin
      fails++; $display("FAIL abort_restart: got latency %0d color %0d expected 441 and 1", cyc, color);
    end
    tests++;
    if (green_cnt < 24 || green_cnt > 26) begin
      fails++; $display("FAIL restart_green: got %0d expected 25+-1", green_cnt);
    end
  endtask

  task automatic test_reset_mid;
    repeat (200) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({s0, s1, s2, s3} !== 4'b1000 || {red_cnt, green_cnt, blue_cnt, clear_cnt} !== 64'd0
        || color !== 2'd0 || color_valid !== 1'b0) begin
      fails++; $display("FAIL reset_mid: got pins %b r%0d g%0d b%0d c%0d col%0d v%0d expected 1000 and zeros",
                        {s0, s1, s2, s3}, red_cnt, green_cnt, blue_cnt, clear_cnt, color, color_valid);
    end
    enable = 1'b0;
  endtask

  task automatic test_saturation;
    int cyc;
    per_red = 4; per_green = 10; per_blue = 20; per_clear = 2;
    @(negedge clock);
    reset2 = 1'b0;
    enable2 = 1'b1;
    cyc = -1;
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clock);
      #1;
      if (valid2) begin
        cyc = k;
        break;
      end
    end
    tests++;
    if (cyc < 0 || c2 !== 4'd15) begin
      fails++; $display("FAIL sat_clear: got %0d (wait %0d) expected 15", c2, cyc);
    end
    tests++;
    if (r2 !== 4'd15) begin
      fails++; $display("FAIL sat_red: got %0d expected 15", r2);
    end
    tests++;
    if (g2 < 9 || g2 > 11 || b2 < 4 || b2 > 6) begin
      fails++; $display("FAIL sat_gb: got g%0d b%0d expected 10+-1 and 5+-1", g2, b2);
    end
    tests++;
    if (color2 !== 2'd1) begin
      fails++; $display("FAIL sat_color: got %0d expected 1", color2);
    end
    enable2 = 1'b0;
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_tie_blue;
    test_dark;
    test_abort;
    test_reset_mid;
    test_saturation;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
